mc_alu: RTL
===========

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal values 4..64.
REQ-002 clk_i  in  1  clock; all state changes on the rising edge.
REQ-003 rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 src1_i  in  WIDTH  operand A.
REQ-005 src2_i  in  WIDTH  operand B.
REQ-006 ctrl_i  in  4  operation select.
REQ-007 valid_i  in  1  request strobe.
REQ-008 ready_o  out  1  block can accept a request.
REQ-009 valid_o  out  1  one-cycle pulse: result_o/zero_o/ovf_o updated.
REQ-010 result_o  out  WIDTH  registered result.
REQ-011 zero_o  out  1  registered, result_o == 0.
REQ-012 ovf_o  out  1  registered signed overflow (ADD/SUB only, else 0).

Function
REQ-013 Request accepted at a rising edge where valid_i=1 and ready_o=1; src1_i, src2_i and ctrl_i captured at that edge; later input changes do not affect the operation.
REQ-014 valid_i while ready_o=0 is ignored: not queued, no effect on the operation in progress.
REQ-015 States: IDLE, EXEC, DONE; ready_o=1 only in IDLE (combinational from state).
REQ-016 Single-cycle ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0 or 1), 1100 NE (result 1 if A!=B else 0), any other code -> result 0; transition IDLE->DONE at accept.
REQ-017 Multi-cycle ops: 1011 MUL (low WIDTH bits of A*B, iterative shift-add), 1101 DIVU (unsigned quotient, restoring), 1110 REMU (unsigned remainder); transition IDLE->EXEC at accept.
REQ-018 EXEC performs exactly WIDTH iterations, one per cycle, counted by an internal counter loaded at accept; after the last iteration EXEC->DONE.
REQ-019 In DONE: valid_o=1 for exactly that cycle with result_o, zero_o, ovf_o updated at the DONE-entry edge; DONE->IDLE unconditionally on the next edge.
REQ-020 Latency from accept edge to valid_o high: 1 cycle single-cycle ops, WIDTH+1 cycles multi-cycle ops; throughput one request per 2 cycles (single) or WIDTH+2 cycles (multi).
REQ-021 result_o, zero_o, ovf_o hold their value from one valid_o pulse until the next.
REQ-022 ovf_o: ADD -> A,B same sign and result sign differs; SUB -> A,B signs differ and result sign differs from A; all other ops 0.
REQ-023 Divide by zero: DIVU result all ones; REMU result = A; still WIDTH+1 latency, no error flag.
REQ-024 MUL/DIVU/REMU treat operands as unsigned; MUL low half identical for signed operands.

Reset
REQ-025 rst_i=1 forces immediately: state IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=0, ovf_o=0, iteration counter and datapath registers 0.
REQ-026 Reset during EXEC or DONE aborts the operation; no valid_o is produced for it.
REQ-027 First request may be accepted on the first rising edge after rst_i deasserts.

Verification (WIDTH=32)
REQ-028 Reset, ADD 0x7FFFFFFF+0x00000001 -> 1 cycle later valid_o=1, result 0x80000000, ovf_o=1, zero_o=0; next cycle valid_o=0, ready_o=1.
REQ-029 SUB 5-5 -> result 0, zero_o=1, ovf_o=0; SLT 0xFFFFFFFF vs 1 -> result 1; NE 7 vs 7 -> result 0, zero_o=1.
REQ-030 MUL 0xFFFFFFFF*3 -> ready_o=0 for 33 cycles, valid_o exactly 33 cycles after accept, result 0xFFFFFFFD; valid_i pulses with other operands during EXEC change nothing.
REQ-031 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each with latency 33.
REQ-032 Start MUL, assert rst_i asynchronously 10 cycles after accept -> ready_o=1, result_o=0, no valid_o; new ADD 2+3 after reset -> result 5 with latency 1.
REQ-033 Undefined ctrl_i 0b1111 with A=B=0xFFFFFFFF -> result 0, zero_o=1, ovf_o=0, latency 1.

Source files
------------

// File: rtl/mc_alu.sv
// Multi-cycle ALU: AND/OR/ADD/SUB/SLT/NE finish in 1 cycle, MUL/DIVU/REMU finish in WIDTH+1 cycles.
// Accepts one request at a time; ready_o is low from accept until the result pulse ends, and requests are not queued.
module mc_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ctrl_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             ovf_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1011;
   localparam logic [3:0] OP_NE   = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101;
   localparam logic [3:0] OP_REMU = 4'b1110;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state;
   logic [3:0]       ctrl_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;   // product accumulator / partial remainder
   logic [WIDTH-1:0] sh;    // shifted multiplicand / dividend becoming quotient
   logic [WIDTH-1:0] opb;   // shifted multiplier / divisor

   logic [WIDTH-1:0] sum, diff, imm_res;
   logic             imm_ovf, is_multi;

   always_comb begin
      sum     = src1_i + src2_i;
      diff    = src1_i - src2_i;
      imm_res = '0;
      imm_ovf = 1'b0;
      case (ctrl_i)
         OP_AND: imm_res = src1_i & src2_i;
         OP_OR:  imm_res = src1_i | src2_i;
         OP_ADD: begin
            imm_res = sum;
            imm_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
         end
         OP_SUB: begin
            imm_res = diff;
            imm_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
         end
         OP_SLT: imm_res[0] = $signed(src1_i) < $signed(src2_i);
         OP_NE:  imm_res[0] = src1_i != src2_i;
         default: imm_res = '0;
      endcase
      is_multi = (ctrl_i == OP_MUL) || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
   end

   logic [WIDTH-1:0] acc_mul, rem_nxt, quo_nxt;
   logic [WIDTH:0]   shifted, trial;

   // One shift-add step for MUL and one restoring step for DIVU/REMU, evaluated in parallel.
   always_comb begin
      acc_mul = opb[0] ? acc + sh : acc;
      shifted = {acc, sh[WIDTH-1]};
      trial   = shifted - {1'b0, opb};
      rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nxt = {sh[WIDTH-2:0], ~trial[WIDTH]};
   end

   assign ready_o = (state == IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         ctrl_q   <= '0;
         cnt      <= '0;
         acc      <= '0;
         sh       <= '0;
         opb      <= '0;
         valid_o  <= 1'b0;
         result_o <= '0;
         zero_o   <= 1'b0;
         ovf_o    <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  ctrl_q <= ctrl_i;
                  if (is_multi) begin
                     state <= EXEC;
                     cnt   <= CW'(WIDTH);
                     acc   <= '0;
                     sh    <= src1_i;
                     opb   <= src2_i;
                  end else begin
                     state    <= DONE;
                     valid_o  <= 1'b1;
                     result_o <= imm_res;
                     zero_o   <= (imm_res == '0);
                     ovf_o    <= imm_ovf;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - CW'(1);
               if (ctrl_q == OP_MUL) begin
                  acc <= acc_mul;
                  sh  <= sh << 1;
                  opb <= opb >> 1;
               end else begin
                  acc <= rem_nxt;
                  sh  <= quo_nxt;
               end
               if (cnt == CW'(1)) begin
                  state   <= DONE;
                  valid_o <= 1'b1;
                  ovf_o   <= 1'b0;
                  if (ctrl_q == OP_MUL) begin
                     result_o <= acc_mul;
                     zero_o   <= (acc_mul == '0);
                  end else if (ctrl_q == OP_DIVU) begin
                     result_o <= quo_nxt;
                     zero_o   <= (quo_nxt == '0);
                  end else begin
                     result_o <= rem_nxt;
                     zero_o   <= (rem_nxt == '0);
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
